// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the IFU, LSU and memory-side handshake signals
//               around mem_port_arbiter. The slave modport is the arbiter's
//               view. The master modport is the surrounding core and memory.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
);
    // Instruction fetch requester (read-only)
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    // Load/store requester
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_wen;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    // Shared physical memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch (IFU,
//               read-only) and load/store (LSU). It runs one transaction at a
//               time: IDLE (arbitrate) -> REQ (issue) -> WAIT (response).
//               The response is returned to the owner as a one-cycle pulse.
//               The default build uses fixed LSU-over-IFU priority.
//               Defining MEM_PORT_ARBITER_RR_EN selects round-robin
//               arbitration instead.
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input  wire                clk,
    input  wire                reset,   // asynchronous, active low
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // Latched request fields, presented to memory while in REQ
    logic              r_owner_lsu;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;

    // Response registers
    logic              r_ifu_resp_valid;
    logic              r_lsu_resp_valid;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic [DATA_W-1:0] r_lsu_rdata;

    // Control wires
    logic              w_idle;
    logic              w_prefer_lsu;
    logic              w_lsu_wins;
    logic              w_ifu_wins;
    logic              w_accept;
    logic              w_issue;
    logic              w_resp_fire;

    assign w_idle = (r_state == c_IDLE);

    // ------------------------------------------------------------------------
    // Arbitration policy. When both requesters are valid, the arbiter grants
    // the LSU only if w_prefer_lsu is set.
    // ------------------------------------------------------------------------
`ifdef MEM_PORT_ARBITER_RR_EN
    // This register records the last winner (1 = LSU). It resets to IFU, so
    // the first conflict goes to the LSU.
    logic r_last_grant;

    assign w_prefer_lsu = ~r_last_grant;

    // Record the winner of every accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_lsu_wins;
        end
    end
`else
    assign w_prefer_lsu = 1'b1;
`endif

    // A requester wins only in IDLE. The two wins are mutually exclusive by
    // construction.
    assign w_lsu_wins = w_idle & bus.lsu_req_valid
                      & (~bus.ifu_req_valid | w_prefer_lsu);
    assign w_ifu_wins = w_idle & bus.ifu_req_valid & ~w_lsu_wins;
    assign w_accept   = w_lsu_wins | w_ifu_wins;

    assign w_issue     = (r_state == c_REQ) & bus.mem_req_ready;
    // A memory response is honoured only while a transaction is waiting for
    // it. A stray response outside WAIT is dropped.
    assign w_resp_fire = (r_state == c_WAIT) & bus.mem_resp_valid;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept)    w_state_nxt = c_REQ;
            c_REQ:  if (w_issue)     w_state_nxt = c_WAIT;
            c_WAIT: if (w_resp_fire) w_state_nxt = c_IDLE;
            default:                 w_state_nxt = c_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winner's request. IFU fetches are reads with a zero mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner_lsu <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
        end else if (w_accept) begin
            r_owner_lsu <= w_lsu_wins;
            if (w_lsu_wins) begin
                r_wen   <= bus.lsu_wen;
                r_addr  <= bus.lsu_addr;
                r_wdata <= bus.lsu_wdata;
                r_wmask <= bus.lsu_wmask;
            end else begin
                r_wen   <= 1'b0;
                r_addr  <= bus.ifu_addr;
                r_wdata <= '0;
                r_wmask <= '0;
            end
        end
    end

    // Generate a one-cycle response pulse to the owner, in the cycle after
    // the memory responds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
        end else begin
            r_ifu_resp_valid <= w_resp_fire & ~r_owner_lsu;
            r_lsu_resp_valid <= w_resp_fire &  r_owner_lsu;
        end
    end

    // Keep read data in the owner's register. It holds between responses.
    // An LSU write acknowledge returns zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
        end else if (w_resp_fire) begin
            if (r_owner_lsu) begin
                r_lsu_rdata <= r_wen ? '0 : bus.mem_rdata;
            end else begin
                r_ifu_rdata <= bus.mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ifu_req_ready  = w_ifu_wins;
    assign bus.lsu_req_ready  = w_lsu_wins;

    assign bus.ifu_resp_valid = r_ifu_resp_valid;
    assign bus.ifu_rdata      = r_ifu_rdata;
    assign bus.lsu_resp_valid = r_lsu_resp_valid;
    assign bus.lsu_rdata      = r_lsu_rdata;

    // The request fields come straight from the capture registers. They stay
    // stable for as long as REQ waits on mem_req_ready.
    assign bus.mem_req_valid  = (r_state == c_REQ);
    assign bus.mem_wen        = r_wen;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wmask      = r_wmask;

    assign busy               = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed testbench for mem_port_arbiter. It includes a memory
//               model with a programmable ready delay and a scoreboard that
//               routes responses. Build with MEM_PORT_ARBITER_RR_EN to expect
//               round-robin grant order.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic        owner_lsu;
        logic [31:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int errors = 0;
    int checks = 0;

    // Memory model controls
    int          ready_delay = 0;
    bit          mem_resp_en = 1'b1;
    bit          mem_pending = 1'b0;
    logic        mem_pend_wen;
    logic [31:0] mem_pend_addr;
    int          wait_cnt = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory model: accepts after ready_delay REQ cycles and responds one
    // cycle after accepting
    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        forever begin
            @(negedge clk);
            if (mem_pending) begin
                if (mem_resp_en) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = mem_pend_wen ? 32'hDEAD_BEEF : mem_data(mem_pend_addr);
                    mem_pending        = 1'b0;
                end
            end else if (bus.mem_req_valid) begin
                chk("mem_req_expected", 32'(req_q.size() != 0), 32'd1);
                if (req_q.size() != 0) begin
                    chk("mem_wen",   32'(bus.mem_wen),   32'(req_q[0].wen));
                    chk("mem_addr",  bus.mem_addr,       req_q[0].addr);
                    chk("mem_wdata", bus.mem_wdata,      req_q[0].wdata);
                    chk("mem_wmask", 32'(bus.mem_wmask), 32'(req_q[0].wmask));
                end
                if (wait_cnt >= ready_delay) begin
                    bus.mem_req_ready = 1'b1;
                    mem_pending       = 1'b1;
                    mem_pend_wen      = bus.mem_wen;
                    mem_pend_addr     = bus.mem_addr;
                    wait_cnt          = 0;
                    if (req_q.size() != 0) void'(req_q.pop_front());
                end else begin
                    wait_cnt++;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
        end
    end

    // Monitor: single-grant check, response routing, and scoreboard push on
    // accept
    initial begin
        rsp_t r;
        req_t q;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("single_ready", 32'(bus.ifu_req_ready & bus.lsu_req_ready), 32'd0);
                if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
                    chk("resp_expected", 32'(rsp_q.size() != 0), 32'd1);
                    chk("resp_onehot", 32'(bus.ifu_resp_valid & bus.lsu_resp_valid), 32'd0);
                    if (rsp_q.size() != 0) begin
                        r = rsp_q.pop_front();
                        chk("resp_owner", 32'(bus.lsu_resp_valid), 32'(r.owner_lsu));
                        chk("resp_data", r.owner_lsu ? bus.lsu_rdata : bus.ifu_rdata, r.data);
                    end
                end
                if (bus.ifu_req_valid && bus.ifu_req_ready) begin
                    q.wen = 1'b0; q.addr = bus.ifu_addr; q.wdata = '0; q.wmask = '0;
                    req_q.push_back(q);
                    r.owner_lsu = 1'b0; r.data = mem_data(bus.ifu_addr);
                    rsp_q.push_back(r);
                end
                if (bus.lsu_req_valid && bus.lsu_req_ready) begin
                    q.wen = bus.lsu_wen; q.addr = bus.lsu_addr;
                    q.wdata = bus.lsu_wdata; q.wmask = bus.lsu_wmask;
                    req_q.push_back(q);
                    r.owner_lsu = 1'b1; r.data = bus.lsu_wen ? 32'd0 : mem_data(bus.lsu_addr);
                    rsp_q.push_back(r);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants;
        int          cyc;
        logic [3:0]  exp_seq;

        bus.ifu_req_valid = 1'b0; bus.ifu_addr  = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_wen   = 1'b0;
        bus.lsu_addr      = '0;   bus.lsu_wdata = '0; bus.lsu_wmask = '0;

        // ---- Reset state
        smp();
        chk("rst_busy",      32'(busy), 0);
        chk("rst_mem_valid", 32'(bus.mem_req_valid), 0);
        chk("rst_ifu_resp",  32'(bus.ifu_resp_valid), 0);
        chk("rst_lsu_resp",  32'(bus.lsu_resp_valid), 0);
        chk("rst_ifu_rdata", bus.ifu_rdata, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        tick();
        reset = 1'b1;

        // ---- IFU read, zero-wait memory
        tick(); bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0000;
        smp();
        chk("t1_ifu_ready", 32'(bus.ifu_req_ready), 1);
        chk("t1_lsu_ready", 32'(bus.lsu_req_ready), 0);
        chk("t1_busy_acc",  32'(busy), 0);
        tick(); bus.ifu_req_valid = 1'b0;
        smp();
        chk("t1_busy_req",  32'(busy), 1);
        chk("t1_mem_valid", 32'(bus.mem_req_valid), 1);
        chk("t1_mem_addr",  bus.mem_addr, 32'h8000_0000);
        tick(); smp();
        chk("t1_busy_wait", 32'(busy), 1);
        chk("t1_mem_valid_wait", 32'(bus.mem_req_valid), 0);
        tick(); smp();
        chk("t1_busy_done", 32'(busy), 0);
        chk("t1_ifu_resp",  32'(bus.ifu_resp_valid), 1);
        chk("t1_ifu_rdata", bus.ifu_rdata, 32'h0010_0073);
        chk("t1_lsu_resp",  32'(bus.lsu_resp_valid), 0);
        tick(); smp();
        chk("t1_ifu_resp_pulse", 32'(bus.ifu_resp_valid), 0);
        chk("t1_ifu_rdata_hold", bus.ifu_rdata, 32'h0010_0073);

        // ---- Conflict: LSU read wins, IFU accepted in LSU response cycle
        tick();
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0200;
        bus.lsu_req_valid = 1'b1; bus.lsu_wen  = 1'b0; bus.lsu_addr = 32'h8000_0100;
        smp();
        chk("t2_lsu_ready", 32'(bus.lsu_req_ready), 1);
        chk("t2_ifu_ready", 32'(bus.ifu_req_ready), 0);
        tick(); bus.lsu_req_valid = 1'b0;
        smp();
        chk("t2_mem_addr",  bus.mem_addr, 32'h8000_0100);
        chk("t2_ifu_ready_req", 32'(bus.ifu_req_ready), 0);
        tick(); smp();
        chk("t2_ifu_ready_wait", 32'(bus.ifu_req_ready), 0);
        tick(); smp();
        chk("t2_lsu_resp",  32'(bus.lsu_resp_valid), 1);
        chk("t2_ifu_ready_resp", 32'(bus.ifu_req_ready), 1);
        chk("t2_lsu_rdata", bus.lsu_rdata, 32'h8000_0100 ^ 32'h1357_9BDF);
        tick(); bus.ifu_req_valid = 1'b0;
        smp();
        chk("t2_mem_addr_ifu", bus.mem_addr, 32'h8000_0200);
        tick(); tick(); smp();
        chk("t2_ifu_resp",  32'(bus.ifu_resp_valid), 1);
        chk("t2_ifu_rdata", bus.ifu_rdata, 32'h8000_0200 ^ 32'h1357_9BDF);

        // ---- LSU byte store, memory ready delayed 3 cycles
        ready_delay = 3;
        tick();
        bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_addr = 32'h8000_0004;
        bus.lsu_wdata = 32'h0000_00AB; bus.lsu_wmask = 8'h01;
        smp();
        chk("t3_lsu_ready", 32'(bus.lsu_req_ready), 1);
        tick();
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = 32'hFFFF_FFFF;
        bus.lsu_wmask = 8'hFF; bus.lsu_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t3_mem_valid", 32'(bus.mem_req_valid), 1);
            chk("t3_mem_wen",   32'(bus.mem_wen), 1);
            chk("t3_mem_addr",  bus.mem_addr, 32'h8000_0004);
            chk("t3_mem_wdata", bus.mem_wdata, 32'h0000_00AB);
            chk("t3_mem_wmask", 32'(bus.mem_wmask), 32'h01);
            tick();
        end
        smp();
        chk("t3_mem_valid_wait", 32'(bus.mem_req_valid), 0);
        tick(); smp();
        chk("t3_lsu_resp",  32'(bus.lsu_resp_valid), 1);
        chk("t3_lsu_rdata", bus.lsu_rdata, 32'd0);
        ready_delay = 0;

        // ---- IFU continuously valid: one accept every 3 cycles
        tick(); bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0010;
        for (int k = 0; k < 10; k++) begin
            smp();
            chk("t4_ifu_ready", 32'(bus.ifu_req_ready), 32'((k % 3) == 0));
            chk("t4_ifu_resp",  32'(bus.ifu_resp_valid), 32'((k > 0) && ((k % 3) == 0)));
            if (k < 9) tick();
        end
        tick(); bus.ifu_req_valid = 1'b0;
        tick(); tick(); smp();
        chk("t4_ifu_resp_drain", 32'(bus.ifu_resp_valid), 1);

        // ---- Reset during WAIT abandons the transaction
        mem_resp_en = 1'b0;
        tick();
        bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_addr = 32'h8000_0040;
        smp();
        chk("t5_lsu_ready", 32'(bus.lsu_req_ready), 1);
        tick(); bus.lsu_req_valid = 1'b0;
        tick();
        tick();
        smp();
        chk("t5_busy_wait", 32'(busy), 1);
        #2; reset = 1'b0; #1;
        chk("t5_busy",       32'(busy), 0);
        chk("t5_mem_valid",  32'(bus.mem_req_valid), 0);
        chk("t5_mem_addr",   bus.mem_addr, 0);
        chk("t5_ifu_rdata",  bus.ifu_rdata, 0);
        chk("t5_lsu_resp",   32'(bus.lsu_resp_valid), 0);
        chk("t5_ifu_resp",   32'(bus.ifu_resp_valid), 0);
        req_q.delete();
        rsp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        mem_resp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t5_no_lsu_resp", 32'(bus.lsu_resp_valid), 0);
            chk("t5_no_ifu_resp", 32'(bus.ifu_resp_valid), 0);
            chk("t5_idle",        32'(busy), 0);
            tick();
        end

        // ---- Both continuously valid: grant order
`ifdef MEM_PORT_ARBITER_RR_EN
        exp_seq = 4'b0101;   // bit i = 1 means grant i goes to the LSU
`else
        exp_seq = 4'b1111;
`endif
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0080;
        bus.lsu_req_valid = 1'b1; bus.lsu_wen  = 1'b0; bus.lsu_addr = 32'h8000_0090;
        grants = 0;
        cyc    = 0;
        while (grants < 4 && cyc < 40) begin
            smp();
            if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                chk("t6_grant_order", 32'(bus.lsu_req_ready), 32'(exp_seq[grants]));
                grants++;
            end
            tick();
            cyc++;
            if (grants == 4) begin
                bus.ifu_req_valid = 1'b0;
                bus.lsu_req_valid = 1'b0;
            end
        end
        chk("t6_grant_count", grants, 4);
        repeat (4) tick();
        smp();
        chk("t6_idle", 32'(busy), 0);

        chk("sb_rsp_empty", rsp_q.size(), 0);
        chk("sb_req_empty", req_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
